// File: rtl/tone_pkg.sv
// Shared types and helpers for the tone sequencer: FSM state encoding,
// voice contribution sign logic and ROM word slicing.
package tone_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StAddr,
        StLoad,
        StPlay
    } state_t;

    // Signed contribution of one square-wave voice; a rest (inactive) contributes nothing.
    function automatic logic signed [31:0] voice_contrib(
        input logic               active,
        input logic               phase,
        input logic signed [31:0] amp
    );
        if (!active) begin
            return 32'sd0;
        end
        return phase ? amp : -amp;
    endfunction

    // Bit offset of voice v inside a packed ROM word of w-bit half-periods.
    function automatic int unsigned voice_offset(input int unsigned v, input int unsigned w);
        return v * w;
    endfunction

endpackage

// File: rtl/tone_voice.sv
// One square-wave oscillator: latches a half-period on load, counts while run is high
// and toggles its phase on each wrap. A zero period is a rest.
module tone_voice
    import tone_pkg::*;
#(
    parameter int unsigned PERIOD_W  = 19,
    parameter int unsigned AMPLITUDE = 50_000_000
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic [PERIOD_W-1:0] period,
    input  logic                load,
    input  logic                run,
    input  logic                clear,
    output logic signed [31:0]  contrib
);

    logic [PERIOD_W-1:0] period_q;
    logic [PERIOD_W-1:0] count_q;
    logic                phase_q;
    logic                active;

    assign active = (period_q != '0);

    always_ff @(posedge clk) begin
        if (!resetn || clear) begin
            period_q <= '0;
            count_q  <= '0;
            phase_q  <= 1'b1;
        end else if (load) begin
            period_q <= period;
            count_q  <= '0;
            phase_q  <= 1'b1;
        end else if (run && active) begin
            if (count_q == period_q - PERIOD_W'(1)) begin
                count_q <= '0;
                phase_q <= ~phase_q;
            end else begin
                count_q <= count_q + PERIOD_W'(1);
            end
        end
    end

    assign contrib = voice_contrib(active, phase_q, signed'(32'(AMPLITUDE)));

endmodule

// File: rtl/tone_sequencer.sv
// Multi-voice square-wave song player: steps a song ROM one beat per word and mixes the
// voices with a pass-through sample for the audio controller.
module tone_sequencer
    import tone_pkg::*;
#(
    parameter int unsigned NUM_VOICES  = 2,
    parameter int unsigned PERIOD_W    = 19,
    parameter int unsigned ADDR_W      = 10,
    parameter int unsigned SONG_LEN    = 1000,
    parameter int unsigned BEAT_CYCLES = 5_000_000,
    parameter int unsigned AMPLITUDE   = 50_000_000
) (
    input  logic                           CLOCK_50,
    input  logic                           resetn,
    input  logic                           start,
    input  logic                           stop,
    input  logic                           pause,
    input  logic                           loop_en,
    output logic [ADDR_W-1:0]              rom_addr,
    input  logic [NUM_VOICES*PERIOD_W-1:0] rom_q,
    input  logic signed [31:0]             mix_in,
    input  logic                           audio_out_allowed,
    output logic signed [31:0]             left_out,
    output logic signed [31:0]             right_out,
    output logic                           write_out,
    output logic                           busy,
    output logic                           done
);

    localparam int unsigned BEAT_W = (BEAT_CYCLES > 1) ? $clog2(BEAT_CYCLES) : 1;
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BEAT_CYCLES - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(SONG_LEN - 1);

    state_t               state;
    logic [BEAT_W-1:0]    beat;
    logic                 beat_end;
    logic                 song_end;
    logic                 voice_load;
    logic                 voice_run;
    logic                 voice_clear;
    logic                 hold_out;
    logic signed [31:0]   contrib [NUM_VOICES];
    logic signed [31:0]   voice_sum;
    logic signed [31:0]   sample_d;
    logic signed [31:0]   sample_q;

    assign beat_end = (state == StPlay) && !pause && (beat == BEAT_LAST);
    // One-shot end of song; stop and start both take precedence over it.
    assign song_end = beat_end && !stop && !start && (rom_addr >= LAST_ADDR) && !loop_en;

    assign voice_load  = (state == StLoad);
    assign voice_run   = (state == StAddr) || (state == StLoad) || ((state == StPlay) && !pause);
    assign voice_clear = stop || song_end;
    assign hold_out    = (state == StPlay) && pause && !stop && !start;

    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            state    <= StIdle;
            rom_addr <= '0;
            beat     <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (stop) begin
                state    <= StIdle;
                rom_addr <= '0;
                beat     <= '0;
                busy     <= 1'b0;
            end else if (start) begin
                state    <= StAddr;
                rom_addr <= '0;
                beat     <= '0;
                busy     <= 1'b1;
            end else begin
                unique case (state)
                    StIdle: state <= StIdle;
                    StAddr: state <= StLoad;
                    StLoad: begin
                        state <= StPlay;
                        beat  <= '0;
                    end
                    StPlay: begin
                        if (beat_end) begin
                            beat <= '0;
                            if (rom_addr < LAST_ADDR) begin
                                rom_addr <= rom_addr + ADDR_W'(1);
                                state    <= StAddr;
                            end else if (loop_en) begin
                                rom_addr <= '0;
                                state    <= StAddr;
                            end else begin
                                rom_addr <= '0;
                                state    <= StIdle;
                                busy     <= 1'b0;
                                done     <= 1'b1;
                            end
                        end else if (!pause) begin
                            beat <= beat + BEAT_W'(1);
                        end
                    end
                    default: state <= StIdle;
                endcase
            end
        end
    end

    for (genvar v = 0; v < NUM_VOICES; v++) begin : g_voice
        tone_voice #(
            .PERIOD_W (PERIOD_W),
            .AMPLITUDE(AMPLITUDE)
        ) u_voice (
            .clk    (CLOCK_50),
            .resetn (resetn),
            .period (rom_q[voice_offset(v, PERIOD_W) +: PERIOD_W]),
            .load   (voice_load),
            .run    (voice_run),
            .clear  (voice_clear),
            .contrib(contrib[v])
        );
    end

    always_comb begin
        voice_sum = '0;
        for (int unsigned v = 0; v < NUM_VOICES; v++) begin
            voice_sum = voice_sum + contrib[v];
        end
        // Silence voices in the same edge that leaves for IDLE so the output is mix_in at once.
        sample_d = mix_in + (voice_clear ? 32'sd0 : voice_sum);
    end

    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            sample_q <= '0;
        end else if (!hold_out) begin
            sample_q <= sample_d;
        end
    end

    assign left_out  = sample_q;
    assign right_out = sample_q;
    assign write_out = audio_out_allowed;

endmodule

// File: tb/tb_tone_sequencer.sv
// Directed bench for tone_sequencer: 2 voices, 20-cycle beat, 3-word song {(4,0),(3,5),(0,0)}.
module tb_tone_sequencer;

    localparam int NV   = 2;
    localparam int PW   = 19;
    localparam int AW   = 4;
    localparam int AMP  = 100000;

    logic               clk = 1'b0;
    logic               resetn;
    logic               start;
    logic               stop;
    logic               pause;
    logic               loop_en;
    logic [AW-1:0]      rom_addr;
    logic [NV*PW-1:0]   rom_q;
    logic signed [31:0] mix_in;
    logic               audio_out_allowed;
    logic signed [31:0] left_out;
    logic signed [31:0] right_out;
    logic               write_out;
    logic               busy;
    logic               done;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    tone_sequencer #(
        .NUM_VOICES (NV),
        .PERIOD_W   (PW),
        .ADDR_W     (AW),
        .SONG_LEN   (3),
        .BEAT_CYCLES(20),
        .AMPLITUDE  (AMP)
    ) dut (
        .CLOCK_50         (clk),
        .resetn           (resetn),
        .start            (start),
        .stop             (stop),
        .pause            (pause),
        .loop_en          (loop_en),
        .rom_addr         (rom_addr),
        .rom_q            (rom_q),
        .mix_in           (mix_in),
        .audio_out_allowed(audio_out_allowed),
        .left_out         (left_out),
        .right_out        (right_out),
        .write_out        (write_out),
        .busy             (busy),
        .done             (done)
    );

    always #5 clk = ~clk;

    // Song ROM: word = {voice1, voice0}, one cycle of read latency.
    function automatic logic [NV*PW-1:0] rom_word(input logic [AW-1:0] a);
        case (a)
            4'd0:    return {19'd0, 19'd4};
            4'd1:    return {19'd5, 19'd3};
            default: return '0;
        endcase
    endfunction

    always_ff @(posedge clk) rom_q <= rom_word(rom_addr);

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int n);
        while (cyc < n) tick();
    endtask

    // Pulse start; afterwards cyc counts cycles with the start cycle as 0.
    task automatic do_start();
        start = 1'b1;
        cyc   = 0;
        tick();
        start = 1'b0;
    endtask

    task automatic do_stop();
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        tick();
        tick();
        checks++;
        if (left_out !== 32'sd0 || right_out !== 32'sd0) begin
            errors++;
            $display("FAIL reset_out: left=%0d right=%0d expected 0", left_out, right_out);
        end
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || rom_addr !== 4'd0) begin
            errors++;
            $display("FAIL reset_ctrl: busy=%b done=%b addr=%0d expected 0 0 0",
                     busy, done, rom_addr);
        end
        resetn = 1'b1;
        tick();
        checks++;
        if (left_out !== 32'sd0) begin
            errors++;
            $display("FAIL idle_out: left=%0d expected 0", left_out);
        end
    endtask

    task automatic test_song();
        bit saw_done = 1'b0;
        do_start();
        checks++;
        if (busy !== 1'b1 || rom_addr !== 4'd0) begin
            errors++;
            $display("FAIL song_start: busy=%b addr=%0d expected 1 0", busy, rom_addr);
        end
        run_to(7);
        checks++;
        if (left_out !== AMP) begin
            errors++;
            $display("FAIL song_c7: left=%0d expected %0d", left_out, AMP);
        end
        tick();
        checks++;
        if (left_out !== -AMP) begin
            errors++;
            $display("FAIL song_c8: left=%0d expected %0d", left_out, -AMP);
        end
        run_to(12);
        checks++;
        if (left_out !== AMP || right_out !== AMP) begin
            errors++;
            $display("FAIL song_c12: left=%0d right=%0d expected %0d", left_out, right_out, AMP);
        end
        run_to(22);
        checks++;
        if (rom_addr !== 4'd0) begin
            errors++;
            $display("FAIL song_c22_addr: addr=%0d expected 0", rom_addr);
        end
        tick();
        checks++;
        if (rom_addr !== 4'd1) begin
            errors++;
            $display("FAIL song_c23_addr: addr=%0d expected 1", rom_addr);
        end
        run_to(26);
        checks++;
        if (left_out !== 2 * AMP) begin
            errors++;
            $display("FAIL song_c26: left=%0d expected %0d", left_out, 2 * AMP);
        end
        run_to(29);
        checks++;
        if (left_out !== 32'sd0) begin
            errors++;
            $display("FAIL song_c29: left=%0d expected 0", left_out);
        end
        run_to(31);
        checks++;
        if (left_out !== -2 * AMP) begin
            errors++;
            $display("FAIL song_c31: left=%0d expected %0d", left_out, -2 * AMP);
        end
        run_to(45);
        checks++;
        if (rom_addr !== 4'd2) begin
            errors++;
            $display("FAIL song_c45_addr: addr=%0d expected 2", rom_addr);
        end
        mix_in = 321;
        run_to(50);
        checks++;
        if (left_out !== 32'sd321) begin
            errors++;
            $display("FAIL song_rest: left=%0d expected 321", left_out);
        end
        while (cyc < 66) begin
            tick();
            if (done === 1'b1) saw_done = 1'b1;
        end
        checks++;
        if (saw_done || busy !== 1'b1) begin
            errors++;
            $display("FAIL song_early_done: done_seen=%b busy=%b expected 0 1", saw_done, busy);
        end
        tick();
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || rom_addr !== 4'd0) begin
            errors++;
            $display("FAIL song_done: done=%b busy=%b addr=%0d expected 1 0 0",
                     done, busy, rom_addr);
        end
        tick();
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL song_done_pulse: done=%b expected 0", done);
        end
        mix_in = 0;
    endtask

    task automatic test_loop();
        bit saw_done = 1'b0;
        bit dropped  = 1'b0;
        loop_en = 1'b1;
        do_start();
        while (cyc < 67) begin
            tick();
            if (done === 1'b1) saw_done = 1'b1;
            if (busy !== 1'b1) dropped = 1'b1;
        end
        checks++;
        if (rom_addr !== 4'd0 || saw_done || dropped) begin
            errors++;
            $display("FAIL loop_wrap: addr=%0d done_seen=%b busy_dropped=%b expected 0 0 0",
                     rom_addr, saw_done, dropped);
        end
        run_to(89);
        checks++;
        if (rom_addr !== 4'd1) begin
            errors++;
            $display("FAIL loop_next: addr=%0d expected 1", rom_addr);
        end
        loop_en = 1'b0;
        do_stop();
    endtask

    task automatic test_pause();
        do_start();
        run_to(10);
        pause = 1'b1;
        run_to(30);
        checks++;
        if (left_out !== -AMP) begin
            errors++;
            $display("FAIL pause_hold: left=%0d expected %0d", left_out, -AMP);
        end
        run_to(60);
        pause = 1'b0;
        run_to(72);
        checks++;
        if (rom_addr !== 4'd0) begin
            errors++;
            $display("FAIL pause_c72: addr=%0d expected 0", rom_addr);
        end
        tick();
        checks++;
        if (rom_addr !== 4'd1) begin
            errors++;
            $display("FAIL pause_c73: addr=%0d expected 1", rom_addr);
        end
        do_stop();
    endtask

    task automatic test_stop();
        do_start();
        run_to(15);
        mix_in = 55;
        do_stop();
        checks++;
        if (busy !== 1'b0 || rom_addr !== 4'd0 || left_out !== 32'sd55) begin
            errors++;
            $display("FAIL stop_mid: busy=%b addr=%0d left=%0d expected 0 0 55",
                     busy, rom_addr, left_out);
        end
        mix_in = 0;
        do_start();
        run_to(66);
        do_stop();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || rom_addr !== 4'd0) begin
            errors++;
            $display("FAIL stop_at_end: done=%b busy=%b addr=%0d expected 0 0 0",
                     done, busy, rom_addr);
        end
    endtask

    task automatic test_restart();
        do_start();
        run_to(30);
        checks++;
        if (rom_addr !== 4'd1) begin
            errors++;
            $display("FAIL restart_pre: addr=%0d expected 1", rom_addr);
        end
        do_start();
        checks++;
        if (rom_addr !== 4'd0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL restart: addr=%0d busy=%b expected 0 1", rom_addr, busy);
        end
        run_to(23);
        checks++;
        if (rom_addr !== 4'd1) begin
            errors++;
            $display("FAIL restart_next: addr=%0d expected 1", rom_addr);
        end
        do_stop();
    endtask

    task automatic test_mid_reset();
        mix_in = 500;
        do_start();
        run_to(30);
        resetn = 1'b0;
        tick();
        checks++;
        if (left_out !== 32'sd0 || busy !== 1'b0 || rom_addr !== 4'd0 || done !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: left=%0d busy=%b addr=%0d done=%b expected 0 0 0 0",
                     left_out, busy, rom_addr, done);
        end
        resetn = 1'b1;
        mix_in = 0;
        tick();
    endtask

    task automatic test_overlap();
        mix_in = 1000;
        do_start();
        run_to(4);
        checks++;
        if (left_out !== 1000 + AMP) begin
            errors++;
            $display("FAIL overlap_one: left=%0d expected %0d", left_out, 1000 + AMP);
        end
        run_to(26);
        checks++;
        if (left_out !== 1000 + 2 * AMP) begin
            errors++;
            $display("FAIL overlap_two: left=%0d expected %0d", left_out, 1000 + 2 * AMP);
        end
        audio_out_allowed = 1'b1;
        #1;
        checks++;
        if (write_out !== 1'b1) begin
            errors++;
            $display("FAIL write_hi: write_out=%b expected 1", write_out);
        end
        audio_out_allowed = 1'b0;
        #1;
        checks++;
        if (write_out !== 1'b0) begin
            errors++;
            $display("FAIL write_lo: write_out=%b expected 0", write_out);
        end
        do_stop();
        mix_in = 0;
    endtask

    initial begin
        resetn            = 1'b0;
        start             = 1'b0;
        stop              = 1'b0;
        pause             = 1'b0;
        loop_en           = 1'b0;
        mix_in            = 32'sd0;
        audio_out_allowed = 1'b0;
        test_reset();
        test_song();
        test_loop();
        test_pause();
        test_stop();
        test_restart();
        test_mid_reset();
        test_overlap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
